// File: rtl/iso14443a_tag_frame_decoder.sv
// ISO14443-A tag response decoder: Manchester slot classification, SOF/EOF,
// byte assembly with odd-parity check, and a small output FIFO.
module iso14443a_tag_frame_decoder #(
    parameter int unsigned HALF_THRESH = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       osc_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mod_strobe,
    input  logic       mod_bit,
    output logic [7:0] byte_data,
    output logic [3:0] byte_nbits,
    output logic       byte_perr,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_error,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  THR = 3'(HALF_THRESH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_DATA} state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [2:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [2:0]  cnt1_now, cnt2_now;
    logic [7:0]  data_q, data_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [1:0]  cls;
    logic        rx_bit;
    logic        push;
    logic [12:0] push_entry;
    logic        fs_d, fe_d, ferr_d;

    // Half counts include the current strobe so slot 7 can classify immediately.
    always_comb begin
        cnt1_now = cnt1_q;
        cnt2_now = cnt2_q;
        if (slot_q[2]) cnt2_now = cnt2_q + {2'b00, mod_bit};
        else           cnt1_now = cnt1_q + {2'b00, mod_bit};
        cls    = {(cnt1_now >= THR), (cnt2_now >= THR)};
        rx_bit = cls[1];
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        data_d     = data_q;
        bitcnt_d   = bitcnt_q;
        push       = 1'b0;
        push_entry = '0;
        fs_d       = 1'b0;
        fe_d       = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                slot_d   = '0;
                cnt1_d   = '0;
                cnt2_d   = '0;
                data_d   = '0;
                bitcnt_d = '0;
                if (enable && mod_strobe && mod_bit) begin
                    state_d = ST_SOF;
                    slot_d  = 3'd1;
                    cnt1_d  = 3'd1;
                end
            end
            ST_SOF, ST_DATA: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else if (mod_strobe) begin
                    slot_d = slot_q + 3'd1;
                    cnt1_d = cnt1_now;
                    cnt2_d = cnt2_now;
                    if (slot_q == 3'd7) begin
                        cnt1_d = '0;
                        cnt2_d = '0;
                        if (state_q == ST_SOF) begin
                            if (cls == 2'b10) begin
                                state_d  = ST_DATA;
                                fs_d     = 1'b1;
                                data_d   = '0;
                                bitcnt_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            case (cls)
                                2'b10, 2'b01: begin
                                    if (bitcnt_q == 4'd8) begin
                                        push       = 1'b1;
                                        push_entry = {data_q, 4'd8, ~^{data_q, rx_bit}};
                                        data_d     = '0;
                                        bitcnt_d   = '0;
                                    end else begin
                                        data_d[bitcnt_q[2:0]] = rx_bit;
                                        bitcnt_d = bitcnt_q + 4'd1;
                                    end
                                end
                                2'b00: begin
                                    if (bitcnt_q != 4'd0 && bitcnt_q != 4'd8) begin
                                        push       = 1'b1;
                                        push_entry = {data_q, bitcnt_q, 1'b0};
                                    end
                                    fe_d    = 1'b1;
                                    state_d = ST_IDLE;
                                end
                                default: begin
                                    ferr_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge osc_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            data_q      <= '0;
            bitcnt_q    <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            data_q      <= data_d;
            bitcnt_q    <= bitcnt_d;
            frame_start <= fs_d;
            frame_end   <= fe_d;
            frame_error <= ferr_d;
        end
    end

    logic [12:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] used;
    logic        full, pop;

    assign used       = wr_ptr - rd_ptr;
    assign full       = (used == DEPTH_V);
    assign byte_valid = (wr_ptr != rd_ptr);
    assign pop        = byte_valid && byte_ready;
    assign {byte_data, byte_nbits, byte_perr} = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push while full is kept.
    always_ff @(negedge osc_clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                if (!full || pop) begin
                    mem[wr_ptr[AW-1:0]] <= push_entry;
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iso14443a_tag_frame_decoder.sv
// Directed bench: stimulus pushes expected FIFO entries into a queue, a
// posedge monitor pops and compares on every valid&ready handshake.
module tb_iso14443a_tag_frame_decoder;

    localparam int GAP = 8;
    localparam logic [1:0] CD = 2'b10, CE = 2'b01, CF = 2'b00, CX = 2'b11;

    logic       osc_clk = 1'b0;
    logic       rst, enable, mod_strobe, mod_bit, byte_ready;
    logic [7:0] byte_data;
    logic [3:0] byte_nbits;
    logic       byte_perr, byte_valid, frame_start, frame_end, frame_error, overflow;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] n;
        logic       p;
    } entry_t;

    entry_t exp_q[$];
    int checks = 0, errors = 0;
    int n_fs = 0, n_fe = 0, n_ferr = 0;

    iso14443a_tag_frame_decoder #(.HALF_THRESH(2), .FIFO_DEPTH(4)) dut (
        .osc_clk(osc_clk), .rst(rst), .enable(enable),
        .mod_strobe(mod_strobe), .mod_bit(mod_bit),
        .byte_data(byte_data), .byte_nbits(byte_nbits), .byte_perr(byte_perr),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_start(frame_start), .frame_end(frame_end),
        .frame_error(frame_error), .overflow(overflow)
    );

    always #5 osc_clk = ~osc_clk;

    // Monitor: mid-cycle sample, inputs change just after the falling edge.
    always @(posedge osc_clk) begin
        entry_t e;
        if (frame_start) n_fs++;
        if (frame_end)   n_fe++;
        if (frame_error) n_ferr++;
        if (byte_valid && byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %h/%0d/%b none expected",
                         byte_data, byte_nbits, byte_perr);
            end else begin
                e = exp_q.pop_front();
                if ({byte_data, byte_nbits, byte_perr} !== e) begin
                    errors++;
                    $display("FAIL pop_entry got %h/%0d/%b expected %h/%0d/%b",
                             byte_data, byte_nbits, byte_perr, e.d, e.n, e.p);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic s, input logic b);
        @(negedge osc_clk);
        #1;
        mod_strobe = s;
        mod_bit    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic slot(input logic b);
        repeat (GAP - 1) tick(1'b0, 1'b0);
        tick(1'b1, b);
    endtask

    task automatic send_cls(input logic [1:0] c);
        repeat (4) slot(c[1]);
        repeat (4) slot(c[0]);
    endtask

    task automatic send_data8(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_cls(d[i] ? CD : CE);
    endtask

    task automatic clr_pulses();
        n_fs = 0; n_fe = 0; n_ferr = 0;
    endtask

    task automatic chk_pulses(input string name, input int fs, input int fe, input int fer);
        chk({name, "_fs"}, n_fs, fs);
        chk({name, "_fe"}, n_fe, fe);
        chk({name, "_ferr"}, n_ferr, fer);
    endtask

    task automatic chk_all_zero(input string name);
        @(posedge osc_clk);
        chk(name, {byte_data, byte_nbits, byte_perr, byte_valid,
                   frame_start, frame_end, frame_error, overflow}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; mod_strobe = 1'b0; mod_bit = 1'b0; byte_ready = 1'b1;
        idle(3);
        chk_all_zero("reset_state");
        @(negedge osc_clk); #1 rst = 1'b0;
        idle(4);
        clr_pulses();

        // Two full bytes, then EOF; byte_valid timing around the first push.
        exp_q.push_back('{8'h04, 4'd8, 1'b0});
        exp_q.push_back('{8'h00, 4'd8, 1'b0});
        send_cls(CD);
        send_data8(8'h04);
        send_cls(CE);
        @(posedge osc_clk);
        chk("valid_before_push", byte_valid, 1'b0);
        tick(1'b0, 1'b0);
        @(posedge osc_clk);
        chk("valid_after_push", byte_valid, 1'b1);
        send_data8(8'h00);
        send_cls(CD);
        send_cls(CF);
        idle(4);
        chk_pulses("two_bytes", 1, 1, 0);
        chk("two_bytes_drained", exp_q.size(), 0);

        // Wrong parity reported in perr.
        clr_pulses();
        exp_q.push_back('{8'h93, 4'd8, 1'b1});
        send_cls(CD);
        send_data8(8'h93);
        send_cls(CE);
        send_cls(CF);
        idle(4);
        chk_pulses("bad_parity", 1, 1, 0);

        // 4-bit ACK partial byte.
        clr_pulses();
        exp_q.push_back('{8'h0A, 4'd4, 1'b0});
        send_cls(CD);
        send_cls(CE); send_cls(CD); send_cls(CE); send_cls(CD);
        send_cls(CF);
        idle(4);
        chk_pulses("ack4", 1, 1, 0);

        // Coding error mid-frame, then a clean frame.
        clr_pulses();
        send_cls(CD);
        send_cls(CD); send_cls(CE);
        send_cls(CX);
        idle(4);
        chk_pulses("coding_err", 1, 0, 1);
        @(posedge osc_clk);
        chk("coding_err_empty", byte_valid, 1'b0);
        clr_pulses();
        exp_q.push_back('{8'h55, 4'd8, 1'b0});
        send_cls(CD);
        send_data8(8'h55);
        send_cls(CD);
        send_cls(CF);
        idle(4);
        chk_pulses("after_err", 1, 1, 0);

        // Overflow: consumer stalled across a 6-byte frame.
        clr_pulses();
        @(negedge osc_clk); #1 byte_ready = 1'b0;
        exp_q.push_back('{8'h11, 4'd8, 1'b0});
        exp_q.push_back('{8'h22, 4'd8, 1'b0});
        exp_q.push_back('{8'h33, 4'd8, 1'b0});
        exp_q.push_back('{8'h44, 4'd8, 1'b0});
        send_cls(CD);
        send_data8(8'h11); send_cls(CD);
        send_data8(8'h22); send_cls(CD);
        send_data8(8'h33); send_cls(CD);
        send_data8(8'h44); send_cls(CD);
        send_data8(8'h55); send_cls(CD);
        send_data8(8'h66); send_cls(CD);
        send_cls(CF);
        idle(4);
        chk_pulses("ovf_frame", 1, 1, 0);
        @(posedge osc_clk);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_valid", byte_valid, 1'b1);
        chk("ovf_head", {byte_data, byte_nbits, byte_perr}, {8'h11, 4'd8, 1'b0});
        @(negedge osc_clk); #1 byte_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        idle(4);
        chk("ovf_drained", exp_q.size(), 0);
        @(posedge osc_clk);
        chk("ovf_empty", byte_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Noise: one modulated slot per half is below threshold.
        clr_pulses();
        slot(1'b1); slot(1'b0); slot(1'b0); slot(1'b0);
        send_cls(CF);
        send_cls(CF);
        idle(4);
        chk_pulses("noise", 0, 0, 0);
        @(posedge osc_clk);
        chk("noise_empty", byte_valid, 1'b0);

        // enable low inside a frame aborts; low in IDLE is silent.
        clr_pulses();
        send_cls(CD);
        send_cls(CD); send_cls(CE);
        idle(1);
        @(negedge osc_clk); #1 enable = 1'b0;
        @(negedge osc_clk); #1 enable = 1'b1;
        idle(4);
        @(negedge osc_clk); #1 enable = 1'b0;
        idle(3);
        @(negedge osc_clk); #1 enable = 1'b1;
        idle(4);
        chk_pulses("abort", 1, 0, 1);
        @(posedge osc_clk);
        chk("abort_empty", byte_valid, 1'b0);

        // rst mid-DATA with a held byte clears everything.
        @(negedge osc_clk); #1 byte_ready = 1'b0;
        send_cls(CD);
        send_data8(8'h11); send_cls(CD);
        send_cls(CD); send_cls(CE); send_cls(CD);
        idle(2);
        @(posedge osc_clk);
        chk("pre_rst_valid", byte_valid, 1'b1);
        @(negedge osc_clk); #1 rst = 1'b1;
        @(negedge osc_clk); #1 rst = 1'b0;
        chk_all_zero("rst_mid_data");
        @(negedge osc_clk); #1 byte_ready = 1'b1;
        idle(4);

        // Clean frame after reset.
        clr_pulses();
        exp_q.push_back('{8'h04, 4'd8, 1'b0});
        send_cls(CD);
        send_data8(8'h04);
        send_cls(CE);
        send_cls(CF);
        idle(6);
        chk_pulses("post_rst", 1, 1, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
